// File: rtl/cog_loader_if.sv
// cog_loader_if: hub read handshake and cog RAM write port of the boot loader.
//   hub_req/hub_addr  : loader -> hub, long-address read request, held until ack
//   hub_ack/hub_rd_data: hub -> loader, read complete with data valid same cycle
//   ram_ena/ram_w/ram_a/ram_d: loader -> cog RAM, write-only port
//   modport master: loader side; modport slave: hub/RAM side
interface cog_loader_if;
    logic        hub_req;
    logic [13:0] hub_addr;
    logic        hub_ack;
    logic [31:0] hub_rd_data;
    logic        ram_ena;
    logic        ram_w;
    logic [8:0]  ram_a;
    logic [31:0] ram_d;
    modport master (
        output hub_req, hub_addr, ram_ena, ram_w, ram_a, ram_d,
        input  hub_ack, hub_rd_data
    );
    modport slave (
        input  hub_req, hub_addr, ram_ena, ram_w, ram_a, ram_d,
        output hub_ack, hub_rd_data
    );
endinterface

// File: rtl/cog_loader.sv
// cog_loader: boot-load sequencer copying LONGS longs from hub memory into cog RAM 0 upward.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle load request, honoured only in IDLE
//   stop      : synchronous abort back to IDLE, no further writes
//   ptr       : hub long address of the first long, latched on accepted start
//   bus       : cog_loader_if.master (hub req/ack read port, cog RAM write port)
//   busy      : high from the cycle after accepted start through done
//   done      : one-cycle completion pulse
//   Macro COG_LOADER_PAR_EN: when defined, an extra write after the last long stores
//   the hub byte address {16'b0, base, 2'b00} at cog address 9'h1F0.
module cog_loader #(
    parameter int LONGS = 496
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [13:0]  ptr,
    cog_loader_if.master bus,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, REQ, WRITE, PAR, DONE} state_t;
    localparam logic [8:0] LAST = 9'(LONGS - 1);
    state_t      state;
    logic [13:0] base;
    logic [8:0]  index;
    logic        armed;
    logic [13:0] next_addr;
    assign next_addr = base + {5'd0, index} + 14'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            index        <= '0;
            armed        <= 1'b0;
            bus.hub_req  <= 1'b0;
            bus.hub_addr <= '0;
            bus.ram_ena  <= 1'b0;
            bus.ram_w    <= 1'b0;
            bus.ram_a    <= '0;
            bus.ram_d    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // armed stays low for the first edge after reset release, so a start
            // coinciding with the release is not taken
            armed       <= 1'b1;
            bus.ram_ena <= 1'b0;
            bus.ram_w   <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                bus.hub_req <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && armed) begin
                        base  <= ptr;
                        index <= '0;
                        state <= REQ;
                    end
                    // entering from IDLE the request is not yet raised: raise it first,
                    // and only listen to ack once hub_req is visibly high
                    REQ: if (!bus.hub_req) begin
                        bus.hub_req  <= 1'b1;
                        bus.hub_addr <= base;
                        busy         <= 1'b1;
                    end else if (bus.hub_ack) begin
                        bus.hub_req <= 1'b0;
                        bus.ram_ena <= 1'b1;
                        bus.ram_w   <= 1'b1;
                        bus.ram_a   <= index;
                        bus.ram_d   <= bus.hub_rd_data;
                        state       <= WRITE;
                    end
                    WRITE: if (index == LAST) begin
`ifdef COG_LOADER_PAR_EN
                        bus.ram_ena <= 1'b1;
                        bus.ram_w   <= 1'b1;
                        bus.ram_a   <= 9'h1F0;
                        bus.ram_d   <= {16'b0, base, 2'b00};
                        state       <= PAR;
`else
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        // next request goes out directly so a zero-wait hub gives 2 cycles/long
                        index        <= index + 9'd1;
                        bus.hub_req  <= 1'b1;
                        bus.hub_addr <= next_addr;
                        state        <= REQ;
                    end
                    PAR: begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/cog_loader.md
# cog_loader

Boot-load sequencer that sits directly upstream of the cog's 512 x 32 register RAM. On a start pulse it fetches a block of longs from hub memory over a req/ack handshake and writes them into cog RAM addresses 0 upward, one long per write cycle. It drives the RAM's `ena`/`w`/`a`/`d` port while the cog is held in its load phase. It reports `busy` during the load and a one-cycle `done` at the end.

## Interface
- `LONGS`, default 496: number of longs loaded; legal range 1..496.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: one-cycle load request; sampled in IDLE only.
- `stop` input, 1 bit: synchronous abort; returns to IDLE with no further writes.
- `ptr` input, 14 bits: hub long address of the first long; latched on accepted `start`.
- `hub_req` output, 1 bit: hub read request.
- `hub_addr` output, 14 bits: hub long address; stable while `hub_req` is high.
- `hub_ack` input, 1 bit: read complete; `hub_rd_data` is valid in the same cycle.
- `hub_rd_data` input, 32 bits: hub read data.
- `ram_ena` output, 1 bit: cog RAM enable.
- `ram_w` output, 1 bit: cog RAM write strobe.
- `ram_a` output, 9 bits: cog RAM address.
- `ram_d` output, 32 bits: cog RAM write data.
- `busy` output, 1 bit: high from the cycle after accepted `start` until `done`, inclusive.
- `done` output, 1 bit: one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Internal state: a base register (14 b), an index register (9 b), a data register (32 b) and the FSM state.
- IDLE
  - `start`=1 latches `ptr` into base, clears index, and moves to REQ.
  - `start` while not in IDLE is ignored.
- REQ
  - `hub_req`=1.
  - `hub_addr` = (base + index) mod 2^14. Wrap-around is required: base 14'h3FFF with index 1 addresses 14'h0000.
  - On `hub_ack`=1, captures `hub_rd_data` and moves to WRITE.
  - `hub_req` and `hub_addr` are held with no change until ack.
- WRITE
  - Single cycle: `ram_ena`=1, `ram_w`=1, `ram_a`=index, `ram_d`=captured data.
  - If index == LONGS-1, go to PAR (macro on) or DONE (macro off).
  - Otherwise index increments and the FSM returns to REQ.
- PAR (macro only)
  - Single cycle: `ram_ena`=1, `ram_w`=1, `ram_a`=9'h1F0, `ram_d`={16'b0, base, 2'b00}.
  - Then moves to DONE.
- DONE
  - `done`=1 for one cycle, then IDLE.
- `stop`=1 in any state goes to IDLE next cycle and deasserts `hub_req`, `ram_*`, `busy` and `done`.
  - `stop` has priority over `hub_ack` in the same cycle; that data is discarded.
  - `stop` and `start` together in IDLE: `stop` wins, and the load is not started.
- `rst` mid-load: immediately returns to IDLE with all outputs 0; the partially written RAM contents are left as-is.
- `ram_ena` is 0 outside WRITE/PAR, so no RAM read traffic is generated.

## Timing
- `start` is sampled at edge 0. At edge 1, `hub_req`=1 and `busy`=1.
- An ack sampled at edge k produces `ram_w`=1 in cycle k+1 and `hub_req`=1 again from cycle k+2 (the next long).
- Minimum of 2 cycles per long, reached when ack arrives in the first REQ cycle.
- Minimum load time with zero-wait ack, start edge to `done` high: 2*LONGS + 1 cycles, plus 1 cycle with the macro.
- `busy` drops in the cycle after `done`. A new `start` is accepted in that cycle (IDLE).
- `hub_ack` while `hub_req`=0 is ignored.

## Configuration
- `COG_LOADER_PAR_EN`
  - Defined: the PAR state is compiled in. After the last long, one extra write puts the hub byte address {16'b0, base, 2'b00} at cog address 9'h1F0.
  - Undefined: the PAR state is absent. WRITE of the last long goes straight to DONE, and address 9'h1F0 is never written.

## Test plan
- LONGS=4, ptr=14'h0100, zero-wait ack, hub data = 32'hA000_0000+addr.
  - Required: writes to RAM 0..3 with 32'hA000_0100..32'hA000_0103.
  - Required: `done` at cycle 9 after start (10 with the macro).
- Random ack stalls of 0..5 cycles.
  - Required: `hub_addr`/`hub_req` stay stable during each stall.
  - Required: exactly one `ram_w` per ack, with no gaps in `ram_a`.
- ptr=14'h3FFE, LONGS=4.
  - Required: hub addresses 3FFE, 3FFF, 0000, 0001.
  - Required: with the macro, RAM[1F0]=32'h0000_FFF8.
- `stop` asserted on the same cycle as the third ack.
  - Required: only RAM 0..1 written, no `done`, `busy`=0 next cycle.
  - Required: a subsequent `start` reloads from index 0.
- `rst` pulsed mid-WRITE.
  - Required: all outputs 0 asynchronously.
  - Required: `start` at the same cycle as `rst` release is ignored; the next `start` is accepted.
- Second `start` pulses during `busy`.
  - Required: ignored, with a single `done`.
  - Required: `start` in the cycle after `done` begins a new load.
